// File: rtl/sad_pkg.sv
// Shared types and constants for the minimum-SAD tracker.
package sad_pkg;

    localparam int unsigned SAD_W_DEF   = 32;
    localparam int unsigned COORD_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SEARCH = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Default-width empty-slot marker; the top uses '1 so any SAD_W works.
    localparam logic [SAD_W_DEF-1:0] SAD_EMPTY = '1;

endpackage

// File: rtl/sad_insert_cell.sv
// One slot of the sorted best-match list: keep, take the candidate, or take the slot above.
module sad_insert_cell
    import sad_pkg::*;
#(
    parameter int unsigned SAD_W   = SAD_W_DEF,
    parameter int unsigned COORD_W = COORD_W_DEF
) (
    input  logic [SAD_W-1:0]   own_sad_i,
    input  logic [COORD_W-1:0] own_row_i,
    input  logic [COORD_W-1:0] own_col_i,
    input  logic [SAD_W-1:0]   up_sad_i,
    input  logic [COORD_W-1:0] up_row_i,
    input  logic [COORD_W-1:0] up_col_i,
    input  logic [SAD_W-1:0]   cand_sad_i,
    input  logic [COORD_W-1:0] cand_row_i,
    input  logic [COORD_W-1:0] cand_col_i,
    input  logic               le_up_i,
    output logic [SAD_W-1:0]   nxt_sad_o,
    output logic [COORD_W-1:0] nxt_row_o,
    output logic [COORD_W-1:0] nxt_col_o,
    output logic               le_o
);

    logic le_own;

    always_comb begin
        // <= lets a later equal candidate rank ahead, and also fills all-ones empty slots.
        le_own    = (cand_sad_i <= own_sad_i);
        le_o      = le_up_i | le_own;
        nxt_sad_o = own_sad_i;
        nxt_row_o = own_row_i;
        nxt_col_o = own_col_i;
        if (le_up_i) begin
            nxt_sad_o = up_sad_i;
            nxt_row_o = up_row_i;
            nxt_col_o = up_col_i;
        end else if (le_own) begin
            nxt_sad_o = cand_sad_i;
            nxt_row_o = cand_row_i;
            nxt_col_o = cand_col_i;
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Streams SAD candidates and keeps the DEPTH lowest, sorted, per search window.
// Optional: define SAD_EARLY_EXIT_EN to end the window on an accepted SAD of zero.
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int unsigned SAD_W   = SAD_W_DEF,
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SAD_W-1:0]           sad_in,
    input  logic [COORD_W-1:0]         row_in,
    input  logic [COORD_W-1:0]         column_in,
    input  logic                       in_last,
    output logic [DEPTH*SAD_W-1:0]     best_sad,
    output logic [DEPTH*COORD_W-1:0]   best_row,
    output logic [DEPTH*COORD_W-1:0]   best_column,
    output logic [$clog2(DEPTH+1)-1:0] best_count,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SAD_W-1:0]   sad_q [DEPTH];
    logic [SAD_W-1:0]   sad_d [DEPTH];
    logic [COORD_W-1:0] row_q [DEPTH];
    logic [COORD_W-1:0] row_d [DEPTH];
    logic [COORD_W-1:0] col_q [DEPTH];
    logic [COORD_W-1:0] col_d [DEPTH];
    logic [SAD_W-1:0]   nxt_sad [DEPTH];
    logic [COORD_W-1:0] nxt_row [DEPTH];
    logic [COORD_W-1:0] nxt_col [DEPTH];
    logic [DEPTH:0]     le_chain;
    logic               accept;
    logic               win_end;

    assign le_chain[0] = 1'b0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam int unsigned Up = (i == 0) ? 0 : i - 1;
        sad_insert_cell #(
            .SAD_W   (SAD_W),
            .COORD_W (COORD_W)
        ) u_cell (
            .own_sad_i  (sad_q[i]),
            .own_row_i  (row_q[i]),
            .own_col_i  (col_q[i]),
            .up_sad_i   (sad_q[Up]),
            .up_row_i   (row_q[Up]),
            .up_col_i   (col_q[Up]),
            .cand_sad_i (sad_in),
            .cand_row_i (row_in),
            .cand_col_i (column_in),
            .le_up_i    (le_chain[i]),
            .nxt_sad_o  (nxt_sad[i]),
            .nxt_row_o  (nxt_row[i]),
            .nxt_col_o  (nxt_col[i]),
            .le_o       (le_chain[i+1])
        );
    end

    assign in_ready = (state_q == ST_SEARCH) && !start;
    assign accept   = in_valid && in_ready;

`ifdef SAD_EARLY_EXIT_EN
    assign win_end = in_last || (sad_in == '0);
`else
    assign win_end = in_last;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        count_d = count_q;
        sad_d   = sad_q;
        row_d   = row_q;
        col_d   = col_q;
        if (start) begin
            state_d = ST_SEARCH;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                sad_d[i] = '1;
                row_d[i] = '0;
                col_d[i] = '0;
            end
        end else if (accept) begin
            sad_d = nxt_sad;
            row_d = nxt_row;
            col_d = nxt_col;
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + 1'b1;
            end
            if (win_end) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sad_q[i] <= '1;
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            count_q <= count_d;
            sad_q   <= sad_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        best_sad    = '0;
        best_row    = '0;
        best_column = '0;
        for (int i = 0; i < DEPTH; i++) begin
            best_sad[i*SAD_W +: SAD_W]        = sad_q[i];
            best_row[i*COORD_W +: COORD_W]    = row_q[i];
            best_column[i*COORD_W +: COORD_W] = col_q[i];
        end
    end

    assign best_count = count_q;
    assign busy       = (state_q == ST_SEARCH);
    assign done       = done_q;

endmodule
